detect_sched: RTL and testbench
===============================

# detect_sched

Round-robin scheduler that time-shares one serial Mealy pattern detector among NREQ serial bit sources. Each requester is granted the detector for one fixed-length frame. The scheduler muxes that requester's bit stream into the detector, counts pattern hits, and reports the per-frame result. It sits between the serial front-end channels and the status/interrupt logic.

## Interface
- NREQ, 4: number of requesters (2..8).
- FRAME_LEN, 16: valid bits per frame (2..255).
- PAT_LEN, 4: pattern length in bits (2..8).
- PATTERN, 4'b1001: pattern to detect, MSB received first, width PAT_LEN.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-low reset; sampled on clk.
- req  in  NREQ  per-requester frame request; level, held until done/abort.
- din  in  NREQ  per-requester serial data bit.
- din_vld  in  NREQ  per-requester bit-valid qualifier.
- grant  out  NREQ  one-hot grant; at most one bit set.
- busy  out  1  frame in progress (RUN state).
- hit  out  1  one-cycle pulse, cycle after the bit completing PATTERN.
- done  out  1  one-cycle pulse, frame completed normally.
- abort  out  1  one-cycle pulse, frame ended by req drop.
- res_id  out  clog2(NREQ)  requester index for done/abort/hit.
- res_cnt  out  8  hit count of the finished frame; saturates at 255.
- stat_sel  in  clog2(NREQ)  statistics read select.
- stat_cnt  out  16  completed-frame count of requester stat_sel.

## Operation
- FSM states are IDLE, RUN and GAP.
- IDLE: if any req, grant the first requesting index at or after rr_ptr (wrap at NREQ), clear the detector, bit counter and hit counter, then go to RUN. With no req, stay in IDLE.
- RUN: detector input is din[g] qualified by din_vld[g], where g is the granted index. Non-granted streams are ignored.
  - Each valid bit advances the detector and increments bit_cnt.
  - On the valid bit where bit_cnt == FRAME_LEN-1, go to GAP: done=1, res_cnt=hit count including any hit on that bit, res_id=g.
  - If req[g]=0 in RUN, go to GAP: abort=1, res_cnt=hits so far, and the bit present that cycle is discarded.
- GAP: grant=0 for exactly one cycle. rr_ptr = g+1 mod NREQ. Then go to IDLE.
- Detector (seq_det_core):
  - Overlapping Mealy matcher over the last PAT_LEN valid bits.
  - Cleared at frame start.
  - hit registered from the completing valid bit.
  - Back-to-back overlapping matches each pulse: PATTERN 1001 on stream 1001001 gives 2 hits.
- Hit counter saturates at 255 and never wraps.
- Reset values: grant=0, busy=0, hit=0, done=0, abort=0, res_id=0, res_cnt=0, stat_cnt=0, rr_ptr=0, state=IDLE.
- Reset mid-frame discards the frame with no done or abort pulse.

## Timing
- Grant latency: req seen in IDLE on cycle n gives grant and busy on n+1.
- First bit accepted is din_vld[g] on cycle n+1.
- hit appears one cycle after the completing bit.
- done/abort, res_id and res_cnt are all valid the cycle after the last bit or the req drop.
- res_id and res_cnt hold until the next done/abort.
- hit on the final bit coincides with done.
- Minimum frame-to-frame turnaround: last bit, then GAP, then IDLE, then grant, i.e. 3 cycles from last bit to next grant.
- din_vld gaps stretch the frame; there is no timeout.
- A simultaneous req drop and final valid bit counts as abort (abort has priority).

## Configuration
- DETECT_SCHED_STATS_EN defined:
  - Per-requester 16-bit saturating counters of done frames (aborts not counted).
  - stat_cnt = counter[stat_sel], registered with one-cycle read latency.
  - Counters cleared by rst.
- Not defined: no counters, stat_cnt tied to 0, stat_sel unused.

## Structure
- Package detect_sched_pkg holds:
  - State enum (IDLE, RUN, GAP).
  - Counter widths: res_cnt 8, stat_cnt 16.
  - Saturation constants.
- Sub-module seq_det_core (params PAT_LEN, PATTERN; ports clk, rst, clr, bit_in, bit_vld, hit): shift register plus compare, registered hit.
- Top level contains the arbiter, FSM, mux, counters and optional stats.

## Test plan
- rst low 2 cycles with req=4'b1111 held: all outputs 0. On rst release, grant=4'b0001 one cycle after the first IDLE.
- req=4'b1111 for four frames of 16 bits each: grant sequence 0001, 0010, 0100, 1000, with 3-cycle gaps between frames. Each done has the matching res_id.
- Requester 2 streams 1001001 then nine zeros: hit pulses 2, done with res_cnt=2 and res_id=2.
- Requester 1 drops req after 5 valid bits: abort=1, res_cnt=0, 1 GAP cycle, then next requester granted. With DETECT_SCHED_STATS_EN, stat_cnt[1] unchanged.
- Frame of 16 valid bits interleaved with din_vld=0 cycles, plus toggling din on non-granted channels: result identical to the gap-free frame.
- Frame ending on a pattern-completing bit: hit and done in the same cycle, and res_cnt includes that hit.

Source files
------------

// File: rtl/detect_sched_pkg.sv
// Shared widths, FSM state codes and saturating helpers for the detect_sched
// round-robin detector scheduler.
package detect_sched_pkg;

    localparam int RES_W  = 8;
    localparam int STAT_W = 16;

    localparam logic [RES_W-1:0]  RES_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    function automatic logic [RES_W-1:0] res_inc(input logic [RES_W-1:0] v, input logic inc);
        return (inc && v != RES_MAX) ? v + 1'b1 : v;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (v != STAT_MAX) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/detect_sched_if.sv
// Requester/result bundle between the serial front-end channels and detect_sched.
interface detect_sched_if
    import detect_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   din;
    logic [NREQ-1:0]   din_vld;
    logic [IDW-1:0]    stat_sel;

    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              hit;
    logic              done;
    logic              abort;
    logic [IDW-1:0]    res_id;
    logic [RES_W-1:0]  res_cnt;
    logic [STAT_W-1:0] stat_cnt;

    modport master (
        output req, din, din_vld, stat_sel,
        input  grant, busy, hit, done, abort, res_id, res_cnt, stat_cnt
    );

    modport slave (
        input  req, din, din_vld, stat_sel,
        output grant, busy, hit, done, abort, res_id, res_cnt, stat_cnt
    );

endinterface

// File: rtl/detect_sched_det.sv
// seq_det_core: overlapping serial pattern matcher with a registered hit.
// A fill counter keeps the cleared shift register from matching all-zero-prefixed patterns.
module seq_det_core #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic hit
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] sh;
    logic [PAT_LEN-1:0] sh_nxt;
    logic [FW-1:0]      fill;

    assign sh_nxt = {sh[PAT_LEN-2:0], bit_in};

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            sh   <= '0;
            fill <= '0;
            hit  <= 1'b0;
        end else begin
            hit <= bit_vld && (fill == FULL) && (sh_nxt == PATTERN);
            if (bit_vld) begin
                sh <= sh_nxt;
                if (fill != FULL) fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/detect_sched.sv
// Round-robin scheduler sharing one seq_det_core across NREQ serial requesters.
// Define DETECT_SCHED_STATS_EN to add per-requester completed-frame counters.
module detect_sched
    import detect_sched_pkg::*;
#(
    parameter int                 NREQ      = 4,
    parameter int                 FRAME_LEN = 16,
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1001
) (
    input logic           clk,
    input logic           rst,
    detect_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

    state_t           state;
    logic [IDW-1:0]   g;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   nxt_g;
    logic [IDW-1:0]   g_inc;
    logic             any_req;
    logic [7:0]       bit_cnt;
    logic [RES_W-1:0] hit_cnt;
    logic [RES_W-1:0] res_base;
    logic [RES_W-1:0] res_cnt_w;
    logic [IDW-1:0]   res_id_q;
    logic             done_q;
    logic             abort_q;

    logic             run;
    logic             cur_req;
    logic             cur_vld;
    logic             cur_din;
    logic             bit_acc;
    logic             done_evt;
    logic             det_clr;
    logic             det_hit;

    // Rotate requests so that rr_ptr sits at bit 0, then take the lowest set offset.
    logic [2*NREQ-1:0] req2;
    logic [NREQ-1:0]   win;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    always_comb begin
        req2    = {bus.req, bus.req};
        win     = NREQ'(req2 >> rr_ptr);
        off     = '0;
        any_req = |bus.req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (win[IDW'(i)]) off = IDW'(i);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        nxt_g = sum[IDW-1:0];
    end

    assign g_inc = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;

    assign run      = (state == ST_RUN);
    assign cur_req  = bus.req[g];
    assign cur_vld  = bus.din_vld[g];
    assign cur_din  = bus.din[g];
    assign bit_acc  = run && cur_req && cur_vld;
    assign done_evt = bit_acc && (bit_cnt == LAST_BIT);
    assign det_clr  = (state == ST_IDLE) && any_req;

    seq_det_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .clr     (det_clr),
        .bit_in  (cur_din),
        .bit_vld (bit_acc),
        .hit     (det_hit)
    );

    // A hit on the final bit lands in the GAP cycle together with done.
    assign res_cnt_w = done_q ? res_inc(res_base, det_hit) : res_base;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            g        <= '0;
            rr_ptr   <= '0;
            bit_cnt  <= '0;
            hit_cnt  <= '0;
            res_base <= '0;
            res_id_q <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        g       <= nxt_g;
                        bit_cnt <= '0;
                        hit_cnt <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hit_cnt <= res_inc(hit_cnt, det_hit);
                    if (!cur_req) begin
                        abort_q  <= 1'b1;
                        res_id_q <= g;
                        res_base <= res_inc(hit_cnt, det_hit);
                        state    <= ST_GAP;
                    end else if (cur_vld) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            done_q   <= 1'b1;
                            res_id_q <= g;
                            res_base <= res_inc(hit_cnt, det_hit);
                            state    <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    res_base <= res_cnt_w;
                    rr_ptr   <= g_inc;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant   = run ? (NREQ'(1) << g) : '0;
    assign bus.busy    = run;
    assign bus.hit     = det_hit;
    assign bus.done    = done_q;
    assign bus.abort   = abort_q;
    assign bus.res_id  = res_id_q;
    assign bus.res_cnt = res_cnt_w;

`ifdef DETECT_SCHED_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] stat_mem;
    logic [STAT_W-1:0]           stat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_mem <= '0;
            stat_q   <= '0;
        end else begin
            if (done_evt) stat_mem[g] <= stat_inc(stat_mem[g]);
            stat_q <= stat_mem[bus.stat_sel];
        end
    end

    assign bus.stat_cnt = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^{bus.stat_sel, done_evt};
    assign bus.stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_detect_sched.sv
// Randomized scoreboard bench for detect_sched: frame results modelled from
// pattern counts over each frame's bit list and a round-robin pointer.
module tb_detect_sched;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int FRAME_LEN = 16;
    localparam int PAT_LEN   = 4;
    localparam logic [PAT_LEN-1:0] PATTERN = 4'b1001;

    logic clk = 1'b0;
    logic rst = 1'b0;

    detect_sched_if #(.NREQ(NREQ)) bus();

    detect_sched #(
        .NREQ      (NREQ),
        .FRAME_LEN (FRAME_LEN),
        .PAT_LEN   (PAT_LEN),
        .PATTERN   (PATTERN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_abort;
        int id;
        int cnt;
        bit fin_hit;
    } exp_t;

    exp_t sbq[$];
    int   fbits[$];
    int   exp_stat[NREQ];
    int   checks = 0;
    int   errors = 0;
    int   rr = 0;
    bit   mon_en = 1'b0;
    int   hcnt = 0;
    int   last_id = 0;
    int   last_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Overlapping occurrences of PATTERN among the first n bits of fbits.
    function automatic int count_hits(input int n);
        int h;
        bit m;
        h = 0;
        for (int i = PAT_LEN - 1; i < n; i++) begin
            m = 1'b1;
            for (int j = 0; j < PAT_LEN; j++)
                if (fbits[i-PAT_LEN+1+j] != int'(PATTERN[PAT_LEN-1-j])) m = 1'b0;
            if (m) h++;
        end
        return h;
    endfunction

    task automatic rand_bits();
        fbits.delete();
        for (int i = 0; i < FRAME_LEN; i++) fbits.push_back(int'($urandom_range(0, 1)));
    endtask

    // Drive one frame; ab_at >= 0 drops req when that valid bit would be sent.
    task automatic do_frame(input logic [NREQ-1:0] rq, input int lat, input int ab_at, input bit gaps);
        int g, cnt, idx, cyc, pos;
        logic [NREQ-1:0] oh, nd, nv;
        exp_t e;
        g = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            pos = (rr + j) % NREQ;
            if (((rq >> pos) & 1) != 0) g = pos;
        end
        oh = NREQ'(1) << g;
        bus.req = rq;
        bus.din_vld = '0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.grant == '0 && cnt < 12);
        chk("grant", bus.grant, oh);
        chk("grant_latency", cnt, lat);
        chk("busy", bus.busy, 1);
        if (bus.grant == '0) return;
        idx = 0;
        cyc = 0;
        forever begin
            nd = NREQ'($urandom);
            nv = NREQ'($urandom);
            if (idx == ab_at) begin
                bus.req     = rq & ~oh;
                bus.din     = (nd & ~oh) | (NREQ'($urandom) & oh);
                bus.din_vld = nv | oh;
                e.is_abort = 1'b1; e.id = g; e.cnt = count_hits(idx); e.fin_hit = 1'b0;
                sbq.push_back(e);
                @(negedge clk);
                break;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.din     = (nd & ~oh) | (NREQ'($urandom) & oh);
                bus.din_vld = nv & ~oh;
            end else begin
                bus.din     = (nd & ~oh) | ((fbits[idx] != 0) ? oh : '0);
                bus.din_vld = nv | oh;
                idx++;
            end
            if (idx == FRAME_LEN) begin
                e.is_abort = 1'b0; e.id = g; e.cnt = count_hits(FRAME_LEN);
                e.fin_hit = (count_hits(FRAME_LEN) != count_hits(FRAME_LEN - 1));
                sbq.push_back(e);
                exp_stat[g]++;
                @(negedge clk);
                break;
            end
            @(negedge clk);
            cyc++;
            chk("grant_hold", bus.grant, oh);
            if (cyc > 200) begin
                chk("frame_timeout", cyc, 0);
                break;
            end
        end
        bus.din_vld = '0;
        chk("gap_grant", bus.grant, 0);
        chk("gap_busy", bus.busy, 0);
        rr = (g + 1) % NREQ;
    endtask

    // Scoreboard monitor: count hit pulses and check each frame result.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.hit) hcnt++;
            if (bus.done || bus.abort) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", {bus.done, bus.abort}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done", bus.done, !e.is_abort);
                    chk("abort", bus.abort, e.is_abort);
                    chk("res_id", bus.res_id, e.id);
                    chk("res_cnt", bus.res_cnt, e.cnt);
                    chk("hit_pulses", hcnt, e.cnt);
                    if (!e.is_abort) chk("final_hit", bus.hit, e.fin_hit);
                    last_id  = e.id;
                    last_cnt = e.cnt;
                end
                hcnt = 0;
            end else begin
                chk("res_id_hold", bus.res_id, last_id);
                chk("res_cnt_hold", bus.res_cnt, last_cnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rq;
        int ab;
        for (int i = 0; i < NREQ; i++) exp_stat[i] = 0;
        bus.req = '1; bus.din = '0; bus.din_vld = '0; bus.stat_sel = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hit", bus.hit, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_abort", bus.abort, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_res_cnt", bus.res_cnt, 0);
        chk("rst_stat_cnt", bus.stat_cnt, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 4; k++) begin
            rand_bits();
            do_frame('1, (k == 0) ? 1 : 2, -1, 1'b0);
        end

        fbits = '{1,0,0,1,0,0,1,0,0,0,0,0,0,0,0,0};
        do_frame(4'b0100, 2, -1, 1'b0);

        rand_bits();
        do_frame(4'b0110, 2, 5, 1'b0);

        fbits = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,1};
        do_frame(4'b0100, 2, -1, 1'b1);

        fbits = '{1,0,0,1,0,0,1,0,0,0,0,0,0,0,0,0};
        do_frame(4'b0100, 2, -1, 1'b1);

        rand_bits();
        do_frame(4'b1011, 2, FRAME_LEN - 1, 1'b0);

        repeat (30) begin
            rand_bits();
            do rq = NREQ'($urandom); while (rq == '0);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1;
            do_frame(rq, 2, ab, 1'b1);
        end

        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.stat_sel = IDW'(i);
            @(negedge clk);
            @(negedge clk);
`ifdef DETECT_SCHED_STATS_EN
            chk("stat_cnt", bus.stat_cnt, exp_stat[i]);
`else
            chk("stat_cnt", bus.stat_cnt, 0);
`endif
        end
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
